// File: rtl/wr_ptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// wr_ptr_full_ctrl : async-FIFO write pointer, full/almost-full, level, overflow
// Rev 1.0
// ============================================================================
module wr_ptr_full_ctrl #(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                 wr_clk,
  input  logic                 wr_rstn,
  input  logic                 wr_en,
  input  logic                 ovf_clr,
  input  logic [ADDR_SIZE:0]   wrq2_rptr,
  output logic                 wr_push,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE:0]   wr_ptr,
  output logic                 wr_full,
  output logic                 wr_almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 wr_overflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] C_AFULL_THRESH = PW'((2 ** ADDR_SIZE) - AFULL_MARGIN);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  assign wr_push = wr_en & ~full_q;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin_sync = '0;
    rbin_sync[PW-1] = wrq2_rptr[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin_sync[i] = rbin_sync[i+1] ^ wrq2_rptr[i];
    end
  end

  always_comb begin
    wbin_d  = wbin_q + {{ADDR_SIZE{1'b0}}, wr_push};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Full when write is exactly one lap ahead: top two Gray bits differ, rest equal
    full_d  = (wgray_d == {~wrq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wrq2_rptr[ADDR_SIZE-2:0]});
    level_d = wbin_d - rbin_sync;
    afull_d = (level_d >= C_AFULL_THRESH);
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr        = wbin_q[ADDR_SIZE-1:0];
  assign wr_ptr         = wgray_q;
  assign wr_full        = full_q;
  assign wr_almost_full = afull_q;
  assign wr_level       = level_q;
  assign wr_overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wr_ptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wr_ptr_full_ctrl : directed bench with a write/read count model of the FIFO
// Rev 1.0
// ============================================================================
module tb_wr_ptr_full_ctrl;

  logic       wr_clk = 1'b0;
  logic       wr_rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [4:0] wrq2_rptr = '0;
  logic       wr_push;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr;
  logic       wr_full;
  logic       wr_almost_full;
  logic [4:0] wr_level;
  logic       wr_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 wr_clk = ~wr_clk;

  wr_ptr_full_ctrl #(.ADDR_SIZE(4), .AFULL_MARGIN(2)) dut (
    .wr_clk         (wr_clk),
    .wr_rstn        (wr_rstn),
    .wr_en          (wr_en),
    .ovf_clr        (ovf_clr),
    .wrq2_rptr      (wrq2_rptr),
    .wr_push        (wr_push),
    .wr_addr        (wr_addr),
    .wr_ptr         (wr_ptr),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  // Decode by search: the count whose Gray code is g
  function automatic int ungray(input logic [4:0] g);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if (gray(k) == g) r = k;
    end
    return r;
  endfunction

  // Model: total accepted writes and read count seen at the last edge, both mod 32
  int m_w = 0;
  int m_r = 0;
  bit m_ovf = 1'b0;

  function automatic int exp_level();
    return (m_w - m_r) & 31;
  endfunction

  function automatic bit exp_full();
    return exp_level() == 16;
  endfunction

  always @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      m_w   <= 0;
      m_r   <= 0;
      m_ovf <= 1'b0;
    end else begin
      if (wr_en && !exp_full()) m_w <= (m_w + 1) & 31;
      m_r <= ungray(wrq2_rptr);
      if (wr_en && exp_full()) m_ovf <= 1'b1;
      else if (ovf_clr)        m_ovf <= 1'b0;
    end
  end

  always @(negedge wr_clk) begin
    check("push",  int'(wr_push),        int'(wr_en && !exp_full()));
    check("addr",  int'(wr_addr),        m_w & 15);
    check("ptr",   int'(wr_ptr),         int'(gray(m_w)));
    check("full",  int'(wr_full),        int'(exp_full()));
    check("afull", int'(wr_almost_full), int'(exp_level() >= 14));
    check("level", int'(wr_level),       exp_level());
    check("ovf",   int'(wr_overflow),    int'(m_ovf));
  end

  // Drive inputs 2 time units after a rising edge, then advance one cycle
  task automatic cyc(input logic we, input logic clr, input logic [4:0] rp);
    wr_en     = we;
    ovf_clr   = clr;
    wrq2_rptr = rp;
    @(posedge wr_clk);
    #2;
  endtask

  int wc;
  int addr_wraps;
  int ptr_wraps;
  int bad_ham;
  int bad_lvl;
  int full_seen;
  logic [3:0] prev_addr;
  logic [4:0] prev_ptr;

  initial begin
    repeat (2) @(posedge wr_clk);
    #2 wr_rstn = 1'b1;

    // Reset mid-stream at wbin=7
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 5'd0);
    check("pre_rst_addr", int'(wr_addr), 7);
    wr_en = 1'b0;
    #1 wr_rstn = 1'b0;
    #1;
    check("rst_addr",  int'(wr_addr),  0);
    check("rst_ptr",   int'(wr_ptr),   0);
    check("rst_level", int'(wr_level), 0);
    check("rst_flags", int'({wr_full, wr_almost_full, wr_overflow}), 0);
    @(posedge wr_clk);
    #2 wr_rstn = 1'b1;

    // Fill 16 words with the reader parked at 0
    wr_en = 1'b1;
    #1 check("first_addr", int'(wr_addr), 0);
    check("first_push", int'(wr_push), 1);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 5'd0);
      check("fill_level", int'(wr_level), i);
      if (i == 13) check("afull_13", int'(wr_almost_full), 0);
      if (i == 14) check("afull_14", int'(wr_almost_full), 1);
      if (i == 15) check("full_15",  int'(wr_full), 0);
    end
    check("full_16", int'(wr_full), 1);
    check("ptr_16",  int'(wr_ptr), 24);

    // Overflow set, clear, set-wins-over-clear
    wr_en = 1'b1;
    #1 check("push_blocked", int'(wr_push), 0);
    cyc(1'b1, 1'b0, 5'd0);
    check("ovf_set",   int'(wr_overflow), 1);
    check("ptr_held",  int'(wr_ptr), 24);
    cyc(1'b0, 1'b1, 5'd0);
    check("ovf_clr",   int'(wr_overflow), 0);
    cyc(1'b1, 1'b1, 5'd0);
    check("ovf_win",   int'(wr_overflow), 1);

    // Drain release by one word, then one accepted write at address 0
    cyc(1'b0, 1'b0, 5'b00001);
    check("drain_full",  int'(wr_full), 0);
    check("drain_level", int'(wr_level), 15);
    wr_en = 1'b1;
    #1 check("drain_addr", int'(wr_addr), 0);
    cyc(1'b1, 1'b0, 5'b00001);
    check("refill_full", int'(wr_full), 1);

    // Simultaneous write and read advance at level 13 (wc=17)
    cyc(1'b0, 1'b0, gray(4));
    check("lvl13", int'(wr_level), 13);
    cyc(1'b1, 1'b0, gray(5));
    check("sim_level", int'(wr_level), 13);
    check("sim_afull", int'(wr_almost_full), 0);

    // Wrap-around with reader trailing by 3 (wc=18)
    wc = 18;
    cyc(1'b0, 1'b0, gray(wc - 3));
    check("wrap_start", int'(wr_level), 3);
    addr_wraps = 0; ptr_wraps = 0; bad_ham = 0; bad_lvl = 0; full_seen = 0;
    for (int i = 0; i < 40; i++) begin
      prev_addr = wr_addr;
      prev_ptr  = wr_ptr;
      cyc(1'b1, 1'b0, gray(wc + 1 - 3));
      wc++;
      if (prev_addr == 4'd15 && wr_addr == 4'd0) addr_wraps++;
      if (prev_ptr == 5'b10000 && wr_ptr == 5'b00000) ptr_wraps++;
      if ($countones(prev_ptr ^ wr_ptr) != 1) bad_ham++;
      if (wr_level != 5'd3) bad_lvl++;
      if (wr_full) full_seen++;
    end
    check("addr_wraps", addr_wraps, 2);
    check("wbin_wraps", ptr_wraps, 1);
    check("hamming",    bad_ham, 0);
    check("wrap_level", bad_lvl, 0);
    check("wrap_full",  full_seen, 0);
    check("wrap_addr",  int'(wr_addr), 10);

    cyc(1'b0, 1'b0, gray(wc - 3));
    repeat (2) @(posedge wr_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
